// File: rtl/board_link_master_if.sv
// Cross-board link bundle: command inputs, the 4-bit link word
// and the session status seen by the host logic.
interface board_link_master_if;
  logic       start;
  logic       stop;
  logic [2:0] target_level;
  logic [3:0] data_out;
  logic       busy;
  logic [9:0] play_sec;
  logic       timeout;

  modport master (
    input  start, stop, target_level,
    output data_out, busy, play_sec, timeout
  );

  modport slave (
    output start, stop, target_level,
    input  data_out, busy, play_sec, timeout
  );
endinterface

// File: rtl/board_link_master.sv
// Master-board link sequencer: ramps the LED level one step per
// hold window and keeps each link word stable for the slave sync.
module board_link_master #(
  parameter int CLK_HZ         = 100000000,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIME_LIMIT_SEC = 999
) (
  input  logic                 clk,
  input  logic                 rst,
  board_link_master_if.master  link
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [CW-1:0] SEC_MAX  = CW'(CLK_HZ - 1);
  localparam logic [9:0]    SEC_LIM  = 10'(TIME_LIMIT_SEC);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      data_q, data_d;
  logic [2:0]      level_q, level_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [CW-1:0]   sec_q, sec_d;
  logic [9:0]      psec_q, psec_d;
  logic            tout_q, tout_d;
  logic            spend_q, spend_d;
  logic            ppend_q, ppend_d;
  logic            hold_ok;
  logic            start_eff;
  logic            stop_eff;

  always_comb begin
    hold_ok   = (hold_q == HOLD_MAX);
    // a fresh pulse acts in its own cycle; stop beats start
    start_eff = spend_q
              | (link.start & ~link.stop & (state_q == IDLE));
    stop_eff  = ppend_q | (link.stop & (state_q == PLAY));

    state_d = state_q;
    data_d  = data_q;
    level_d = level_q;
    sec_d   = sec_q;
    psec_d  = psec_q;
    tout_d  = tout_q;
    spend_d = (state_q == IDLE) ? start_eff : 1'b0;
    ppend_d = (state_q == PLAY) ? stop_eff : 1'b0;

    unique case (state_q)
      IDLE: begin
        data_d = 4'b0000;
        if (start_eff && hold_ok) begin
          data_d  = 4'b1000;
          level_d = 3'd0;
          psec_d  = 10'd0;
          sec_d   = '0;
          tout_d  = 1'b0;
          spend_d = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (sec_q == SEC_MAX) begin
          sec_d = '0;
          if (psec_q != 10'h3ff) psec_d = psec_q + 10'd1;
        end else begin
          sec_d = sec_q + 1'b1;
        end
        if (TIME_LIMIT_SEC != 0 && psec_d == SEC_LIM) tout_d = 1'b1;
        if (hold_ok) begin
          if (stop_eff || tout_q) begin
            state_d = DRAIN;
            ppend_d = 1'b0;
          end else begin
            if (level_q < link.target_level)
              level_d = level_q + 3'd1;
            else if (level_q > link.target_level)
              level_d = level_q - 3'd1;
            data_d = {1'b1, level_d};
          end
        end
      end
      DRAIN: begin
        if (hold_ok) begin
          if (level_q != 3'd0) begin
            level_d = level_q - 3'd1;
            data_d  = {1'b1, level_d};
          end else begin
            data_d  = 4'b0000;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (data_d != data_q)
      hold_d = '0;
    else if (hold_ok)
      hold_d = hold_q;
    else
      hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= 4'b0000;
      level_q <= 3'd0;
      hold_q  <= HOLD_MAX;
      sec_q   <= '0;
      psec_q  <= 10'd0;
      tout_q  <= 1'b0;
      spend_q <= 1'b0;
      ppend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      level_q <= level_d;
      hold_q  <= hold_d;
      sec_q   <= sec_d;
      psec_q  <= psec_d;
      tout_q  <= tout_d;
      spend_q <= spend_d;
      ppend_q <= ppend_d;
    end
  end

  assign link.data_out = data_q;
  assign link.busy     = (state_q != IDLE);
  assign link.play_sec = psec_q;
  assign link.timeout  = tout_q;

endmodule
